// File: rtl/if_stage_pkg.sv
// rtl/if_stage_pkg.sv - shared constants, state encodings and icache field ranges for if_stage
//
// Purpose: single definition point for the fetch stage's reset level, bus
// widths, zero word, FSM states and the icache index/tag bit positions.
// Ports: none (package).

package if_stage_pkg;

  localparam logic RST_ENABLE = 1'b1;

  localparam int INST_ADDR_W = 32;
  localparam int INST_DATA_W = 32;

  localparam logic [INST_DATA_W-1:0] ZERO_WORD = '0;
  localparam logic [INST_ADDR_W-1:0] PC_STEP   = INST_ADDR_W'(4);

  // Direct-mapped icache: index = pc[7:2], tag = pc[17:8]
  localparam int IDX_LSB     = 2;
  localparam int IDX_MSB     = 7;
  localparam int TAG_LSB     = 8;
  localparam int TAG_MSB     = 17;
  localparam int IDX_W       = IDX_MSB - IDX_LSB + 1;
  localparam int TAG_W       = TAG_MSB - TAG_LSB + 1;
  localparam int CACHE_DEPTH = 1 << IDX_W;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_MEM = 2'd1,
    ST_HOLD     = 2'd2,
    ST_DISCARD  = 2'd3
  } if_state_e;

endpackage

// File: rtl/if_stage_icache.sv
// rtl/if_stage_icache.sv - direct-mapped instruction cache array (lookup plus write port)
//
// Purpose: 64-entry direct-mapped store of {valid, tag, word}.
// Ports:
//   clk_in, rst_in        clock, synchronous active-high reset (clears valid bits)
//   rd_index, rd_tag      combinational lookup key
//   rd_hit, rd_word       lookup result
//   wr_en, wr_index,
//   wr_tag, wr_word       unconditional overwrite of the indexed entry

module icache
  import if_stage_pkg::*;
(
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic [IDX_W-1:0]       rd_index,
  input  logic [TAG_W-1:0]       rd_tag,
  output logic                   rd_hit,
  output logic [INST_DATA_W-1:0] rd_word,
  input  logic                   wr_en,
  input  logic [IDX_W-1:0]       wr_index,
  input  logic [TAG_W-1:0]       wr_tag,
  input  logic [INST_DATA_W-1:0] wr_word
);

  logic [CACHE_DEPTH-1:0] valid;
  logic [TAG_W-1:0]       tags  [CACHE_DEPTH];
  logic [INST_DATA_W-1:0] words [CACHE_DEPTH];

  // Only the valid bits need a reset; tag/data stay reset-free so the
  // arrays can map onto plain RAM.
  always_ff @(posedge clk_in) begin
    if (rst_in == RST_ENABLE) begin
      valid <= '0;
    end else if (wr_en) begin
      valid[wr_index] <= 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (wr_en) begin
      tags[wr_index]  <= wr_tag;
      words[wr_index] <= wr_word;
    end
  end

  assign rd_hit  = valid[rd_index] && (tags[rd_index] == rd_tag);
  assign rd_word = words[rd_index];

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage with direct-mapped icache and miss FSM
//
// Purpose: generates the PC, looks it up in the icache, fetches misses from
// the memory controller and presents pc/instruction to the IF/ID register.
// Ports:
//   clk_in, rst_in, rdy_in          clock, sync active-high reset, global ready
//   stall_in[5:0]                   stall vector; bit 0 freezes PC generation
//   branch_flag_in/target_in        one-cycle redirect from EX
//   mem_req_out, mem_addr_out       fetch request to memory controller
//   mem_done_in, mem_data_in        fetch completion pulse and word
//   pc_out, inst_out                IF/ID outputs (0/0 when nothing is emitted)
//   stall_req_out                   asks for an IF freeze while a miss is pending

module if_stage
  import if_stage_pkg::*;
(
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   rdy_in,
  input  logic [5:0]             stall_in,
  input  logic                   branch_flag_in,
  input  logic [INST_ADDR_W-1:0] branch_target_in,
  output logic                   mem_req_out,
  output logic [INST_ADDR_W-1:0] mem_addr_out,
  input  logic                   mem_done_in,
  input  logic [INST_DATA_W-1:0] mem_data_in,
  output logic [INST_ADDR_W-1:0] pc_out,
  output logic [INST_DATA_W-1:0] inst_out,
  output logic                   stall_req_out
);

  if_state_e              state;
  logic [INST_ADDR_W-1:0] pc;
  logic [INST_DATA_W-1:0] hold_word;
  logic                   cache_hit;
  logic [INST_DATA_W-1:0] cache_word;
  logic                   cache_we;
  logic                   stall_if;
  logic                   unused_stall;

  assign stall_if     = stall_in[0];
  assign unused_stall = ^stall_in[5:1];

  // A returning word is always written back, even when a redirect makes it
  // stale for the pipeline; it is still a correct copy of memory.
  assign cache_we = (rst_in != RST_ENABLE) && rdy_in && mem_done_in &&
                    ((state == ST_WAIT_MEM) || (state == ST_DISCARD));

  icache u_icache (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .rd_index (pc[IDX_MSB:IDX_LSB]),
    .rd_tag   (pc[TAG_MSB:TAG_LSB]),
    .rd_hit   (cache_hit),
    .rd_word  (cache_word),
    .wr_en    (cache_we),
    .wr_index (mem_addr_out[IDX_MSB:IDX_LSB]),
    .wr_tag   (mem_addr_out[TAG_MSB:TAG_LSB]),
    .wr_word  (mem_data_in)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in == RST_ENABLE) begin
      state         <= ST_IDLE;
      pc            <= '0;
      pc_out        <= '0;
      inst_out      <= ZERO_WORD;
      hold_word     <= ZERO_WORD;
      mem_req_out   <= 1'b0;
      mem_addr_out  <= '0;
      stall_req_out <= 1'b0;
    end else if (rdy_in) begin
      // Default: bubble; only the emit paths below override it.
      pc_out   <= '0;
      inst_out <= ZERO_WORD;
      if (branch_flag_in) begin
        pc <= branch_target_in;
        case (state)
          ST_WAIT_MEM, ST_DISCARD: begin
            if (mem_done_in) begin
              mem_req_out   <= 1'b0;
              stall_req_out <= 1'b0;
              state         <= ST_IDLE;
            end else begin
              // Request keeps its old address until memory answers.
              state <= ST_DISCARD;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end else begin
        case (state)
          ST_IDLE: begin
            if (cache_hit) begin
              if (!stall_if) begin
                pc_out   <= pc;
                inst_out <= cache_word;
                pc       <= pc + PC_STEP;
              end else begin
                hold_word <= cache_word;
                state     <= ST_HOLD;
              end
            end else begin
              mem_req_out   <= 1'b1;
              mem_addr_out  <= pc;
              stall_req_out <= 1'b1;
              state         <= ST_WAIT_MEM;
            end
          end
          ST_WAIT_MEM: begin
            if (mem_done_in) begin
              mem_req_out   <= 1'b0;
              stall_req_out <= 1'b0;
              if (!stall_if) begin
                pc_out   <= pc;
                inst_out <= mem_data_in;
                pc       <= pc + PC_STEP;
                state    <= ST_IDLE;
              end else begin
                hold_word <= mem_data_in;
                state     <= ST_HOLD;
              end
            end
          end
          ST_HOLD: begin
            if (!stall_if) begin
              pc_out   <= pc;
              inst_out <= hold_word;
              pc       <= pc + PC_STEP;
              state    <= ST_IDLE;
            end
          end
          ST_DISCARD: begin
            if (mem_done_in) begin
              mem_req_out   <= 1'b0;
              stall_req_out <= 1'b0;
              state         <= ST_IDLE;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - directed self-checking bench for if_stage

module tb_if_stage;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic [5:0]  stall_in;
  logic        branch_flag_in;
  logic [31:0] branch_target_in;
  logic        mem_req_out;
  logic [31:0] mem_addr_out;
  logic        mem_done_in;
  logic [31:0] mem_data_in;
  logic [31:0] pc_out;
  logic [31:0] inst_out;
  logic        stall_req_out;

  int errors = 0;
  int checks = 0;

  if_stage dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .rdy_in           (rdy_in),
    .stall_in         (stall_in),
    .branch_flag_in   (branch_flag_in),
    .branch_target_in (branch_target_in),
    .mem_req_out      (mem_req_out),
    .mem_addr_out     (mem_addr_out),
    .mem_done_in      (mem_done_in),
    .mem_data_in      (mem_data_in),
    .pc_out           (pc_out),
    .inst_out         (inst_out),
    .stall_req_out    (stall_req_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk1(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] pc_e, input logic [31:0] inst_e,
                     input logic req_e, input logic [31:0] addr_e, input logic stall_e);
    chk1({tag, ".pc_out"},        pc_out,                pc_e);
    chk1({tag, ".inst_out"},      inst_out,              inst_e);
    chk1({tag, ".mem_req_out"},   {31'd0, mem_req_out},  {31'd0, req_e});
    chk1({tag, ".mem_addr_out"},  mem_addr_out,          addr_e);
    chk1({tag, ".stall_req_out"}, {31'd0, stall_req_out}, {31'd0, stall_e});
  endtask

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; stall_in = 6'd0;
    branch_flag_in = 1'b0; branch_target_in = 32'd0;
    mem_done_in = 1'b0; mem_data_in = 32'd0;

    tick(); chk("reset", 0, 0, 0, 0, 0);
    rst_in = 1'b0;

    // Cold miss at 0x0, answered after 3 request cycles
    tick(); chk("miss0_c1", 0, 0, 1, 0, 1);
    tick(); chk("miss0_c2", 0, 0, 1, 0, 1);
    tick(); chk("miss0_c3", 0, 0, 1, 0, 1);
    mem_done_in = 1'b1; mem_data_in = 32'h0000_0013;
    tick(); chk("fill0", 32'h0, 32'h13, 0, 0, 0);
    mem_done_in = 1'b0;

    // Redirect to 0x0, then a one-cycle hit
    branch_flag_in = 1'b1; branch_target_in = 32'h0;
    tick(); chk("br0", 0, 0, 0, 0, 0);
    branch_flag_in = 1'b0;
    tick(); chk("hit0", 32'h0, 32'h13, 0, 0, 0);

    // Miss at 0x4 frozen by rdy_in=0 for 4 cycles
    tick(); chk("miss4", 0, 0, 1, 32'h4, 1);
    rdy_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(); chk("frozen", 0, 0, 1, 32'h4, 1);
    end
    rdy_in = 1'b1;
    tick(); chk("resume", 0, 0, 1, 32'h4, 1);
    mem_done_in = 1'b1; mem_data_in = 32'hAAAA_0004;
    tick(); chk("fill4", 32'h4, 32'hAAAA_0004, 0, 32'h4, 0);
    mem_done_in = 1'b0;

    // Redirect to 0x100 while 0x8 is outstanding
    tick(); chk("miss8", 0, 0, 1, 32'h8, 1);
    branch_flag_in = 1'b1; branch_target_in = 32'h100;
    tick(); chk("br_wait", 0, 0, 1, 32'h8, 1);
    branch_flag_in = 1'b0;
    mem_done_in = 1'b1; mem_data_in = 32'hBBBB_0008;
    tick(); chk("discard", 0, 0, 0, 32'h8, 0);
    mem_done_in = 1'b0;

    // 0x100 aliases index 0 with a different tag
    tick(); chk("alias100", 0, 0, 1, 32'h100, 1);
    mem_done_in = 1'b1; mem_data_in = 32'hCCCC_0100;
    tick(); chk("fill100", 32'h100, 32'hCCCC_0100, 0, 32'h100, 0);
    mem_done_in = 1'b0;
    branch_flag_in = 1'b1; branch_target_in = 32'h0;
    tick(); chk("br0b", 0, 0, 0, 32'h100, 0);
    branch_flag_in = 1'b0;
    tick(); chk("alias0", 0, 0, 1, 32'h0, 1);
    mem_done_in = 1'b1; mem_data_in = 32'h0000_0013;
    tick(); chk("refill0", 32'h0, 32'h13, 0, 32'h0, 0);
    mem_done_in = 1'b0;

    // Discarded word for 0x8 must now hit
    branch_flag_in = 1'b1; branch_target_in = 32'h8;
    tick(); chk("br8", 0, 0, 0, 32'h0, 0);
    branch_flag_in = 1'b0;
    tick(); chk("stale8", 32'h8, 32'hBBBB_0008, 0, 32'h0, 0);

    // Fill 0x40, then hit it under a 2-cycle stall
    branch_flag_in = 1'b1; branch_target_in = 32'h40;
    tick(); chk("br40", 0, 0, 0, 32'h0, 0);
    branch_flag_in = 1'b0;
    tick(); chk("miss40", 0, 0, 1, 32'h40, 1);
    mem_done_in = 1'b1; mem_data_in = 32'hDDDD_0040;
    tick(); chk("fill40", 32'h40, 32'hDDDD_0040, 0, 32'h40, 0);
    mem_done_in = 1'b0;
    branch_flag_in = 1'b1; branch_target_in = 32'h40;
    tick(); chk("br40b", 0, 0, 0, 32'h40, 0);
    branch_flag_in = 1'b0; stall_in = 6'b000001;
    tick(); chk("hold1", 0, 0, 0, 32'h40, 0);
    tick(); chk("hold2", 0, 0, 0, 32'h40, 0);
    stall_in = 6'b000000;
    tick(); chk("release", 32'h40, 32'hDDDD_0040, 0, 32'h40, 0);
    tick(); chk("miss44", 0, 0, 1, 32'h44, 1);
    mem_done_in = 1'b1; mem_data_in = 32'h4444_4444;
    tick(); chk("fill44", 32'h44, 32'h4444_4444, 0, 32'h44, 0);
    mem_done_in = 1'b0;

    // PC wrap from 0xFFFFFFFC to 0x0 (0x0 is cached)
    branch_flag_in = 1'b1; branch_target_in = 32'hFFFF_FFFC;
    tick(); chk("brtop", 0, 0, 0, 32'h44, 0);
    branch_flag_in = 1'b0;
    tick(); chk("misstop", 0, 0, 1, 32'hFFFF_FFFC, 1);
    mem_done_in = 1'b1; mem_data_in = 32'hFFFF_0001;
    tick(); chk("filltop", 32'hFFFF_FFFC, 32'hFFFF_0001, 0, 32'hFFFF_FFFC, 0);
    mem_done_in = 1'b0;
    tick(); chk("wrap", 32'h0, 32'h13, 0, 32'hFFFF_FFFC, 0);

    // Branch and mem_done_in on the same edge in WAIT_MEM
    branch_flag_in = 1'b1; branch_target_in = 32'h300;
    tick(); chk("br300", 0, 0, 0, 32'hFFFF_FFFC, 0);
    branch_flag_in = 1'b0;
    tick(); chk("miss300", 0, 0, 1, 32'h300, 1);
    branch_flag_in = 1'b1; branch_target_in = 32'h0;
    mem_done_in = 1'b1; mem_data_in = 32'hEEEE_0300;
    tick(); chk("br_done", 0, 0, 0, 32'h300, 0);
    branch_flag_in = 1'b0; mem_done_in = 1'b0;
    tick(); chk("alias0b", 0, 0, 1, 32'h0, 1);

    // Reset mid-request; late done is ignored and cache is invalid
    rst_in = 1'b1;
    tick(); chk("reset2", 0, 0, 0, 0, 0);
    rst_in = 1'b0;
    mem_done_in = 1'b1; mem_data_in = 32'h1234_5678;
    tick(); chk("rst_ign", 0, 0, 1, 0, 1);
    mem_done_in = 1'b0;
    tick(); chk("rst_wait", 0, 0, 1, 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 clk_in  input  1  system clock; all state updates on its rising edge.
REQ-002 rst_in  input  1  synchronous, active-high reset.
REQ-003 rdy_in  input  1  global ready; when 0, every register holds its value.
REQ-004 stall_in  input  6  stall vector from the stall controller; bit 0 freezes PC generation.
REQ-005 branch_flag_in  input  1  one-cycle redirect pulse from EX.
REQ-006 branch_target_in  input  32  redirect PC; valid while branch_flag_in=1.
REQ-007 mem_req_out  output  1  fetch request to the memory controller.
REQ-008 mem_addr_out  output  32  word-aligned fetch address.
REQ-009 mem_done_in  input  1  one-cycle pulse: mem_data_in holds the requested word.
REQ-010 mem_data_in  input  32  fetched instruction word.
REQ-011 pc_out  output  32  PC presented to the IF/ID register.
REQ-012 inst_out  output  32  instruction presented to the IF/ID register; 0 means bubble.
REQ-013 stall_req_out  output  1  request to the stall controller to freeze IF while a miss is outstanding.

Function
REQ-014 The FSM SHALL have four states: IDLE, WAIT_MEM, HOLD and DISCARD.
REQ-015 The direct-mapped icache SHALL have 64 entries, each holding a valid bit, a tag and a 32-bit word.
- Index: pc[7:2].
- Tag: pc[17:8].
REQ-016 IDLE, cache hit, stall_in[0]=0: next edge SHALL load pc_out<=pc, inst_out<=word and pc<=pc+4, so a hit costs 1 cycle.
REQ-017 IDLE, cache hit, stall_in[0]=1: the block SHALL latch the word into a hold register, keep pc unchanged, drive inst_out=0 and enter HOLD.
REQ-018 HOLD: when stall_in[0]=0, the block SHALL emit the held pc/word exactly as in REQ-016 and return to IDLE.
REQ-019 IDLE, cache miss: the block SHALL set mem_req_out=1, mem_addr_out=pc and stall_req_out=1, drive inst_out=0 and enter WAIT_MEM.
REQ-020 WAIT_MEM: mem_req_out and mem_addr_out SHALL stay stable until mem_done_in=1.
REQ-021 On mem_done_in=1 in WAIT_MEM, on the same edge the block SHALL:
- write the cache entry (valid=1, tag, word);
- drop mem_req_out and stall_req_out;
- then behave as a hit: REQ-016 if stall_in[0]=0, REQ-017 if stall_in[0]=1.
REQ-022 branch_flag_in=1 SHALL take priority over every other condition in every state.
- pc<=branch_target_in; pc_out<=0; inst_out<=0.
- From IDLE or HOLD: go to IDLE.
- From WAIT_MEM with mem_done_in=0: go to DISCARD, keeping mem_req_out=1 and the old address.
- From WAIT_MEM with mem_done_in=1 on the same edge: write the cache, discard the word, go to IDLE.
REQ-023 DISCARD: on mem_done_in=1 the block SHALL write the cache, emit nothing, drop mem_req_out and stall_req_out, and go to IDLE.
REQ-024 The PC increment SHALL be 32-bit modulo; 0xFFFFFFFC+4 wraps to 0x00000000.
REQ-025 A cache write SHALL overwrite the indexed entry unconditionally (no replacement policy).
REQ-026 In any cycle with no instruction emitted, the block SHALL drive pc_out=0 and inst_out=0.

Reset
REQ-027 On rst_in=1 at a clock edge, the block SHALL set all of the following, regardless of rdy_in:
- pc, pc_out, inst_out and mem_addr_out to 0;
- mem_req_out and stall_req_out to 0;
- FSM state to IDLE;
- all 64 cache valid bits to 0.
REQ-028 A reset during WAIT_MEM or DISCARD SHALL abandon the request; a later mem_done_in while in IDLE with mem_req_out=0 SHALL be ignored.

Structure
REQ-029 The following SHALL live in the shared define file:
- the reset-level constant;
- the zero-word constant;
- the instruction address/data bus widths;
- the state encodings;
- the cache index/tag bit ranges.
REQ-030 The icache array (lookup plus write port) SHALL be a sub-module named icache, instantiated once inside if_stage.

Verification
REQ-031 Reset, pc=0 miss, mem_done_in with 0x00000013 after 3 cycles -> mem_req_out=1 with addr 0x0 for 3 cycles; next edge pc_out=0x0, inst_out=0x13, pc=0x4.
REQ-032 Refetch of 0x0 after a branch to 0x0 -> hit; pc_out=0x0, inst_out=0x13 one cycle after the redirect, with no mem_req_out.
REQ-033 Hit at 0x40 with stall_in[0]=1 for 2 cycles -> inst_out=0 for 2 cycles, then pc_out=0x40 with the held word, then pc=0x44.
REQ-034 branch_flag_in to 0x100 during WAIT_MEM for 0x8 -> stale word written to cache but not emitted; next request addr 0x100.
REQ-035 Alias test: fetch 0x0 then 0x100 (same index) -> second access misses and the entry is replaced; fetch 0x0 again misses.
REQ-036 rdy_in=0 for 4 cycles mid-WAIT_MEM (no done) -> all outputs frozen; operation resumes unchanged afterwards.
